// File: rtl/stb_readout_sequencer.sv
// Sequences one Streaming Trace Buffer capture: control write, status poll, DEPTH-word drain.
// Define STB_READOUT_TIMEOUT_EN to build the poll watchdog (TIMEOUT_CYCLES) that drives ERROR_O.
module stb_readout_sequencer #(
    parameter int CTRL_WIDTH     = 32,
    parameter int STAT_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 64,
    parameter int EVENT_BIT      = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic                         START_I,
    input  logic                         ABORT_I,
    input  logic [CTRL_WIDTH-1:0]        CONFIG_I,
    output logic                         BUSY_O,
    output logic                         DONE_O,
    output logic                         ERROR_O,
    output logic [$clog2(DEPTH+1)-1:0]   WORD_COUNT_O,
    output logic [STAT_WIDTH-1:0]        STATUS_CAPT_O,
    input  logic                         CONTROL_READY_I,
    output logic                         CONTROL_VALID_O,
    output logic [CTRL_WIDTH-1:0]        CONTROL_O,
    output logic                         STATUS_READY_O,
    input  logic                         STATUS_VALID_I,
    input  logic [STAT_WIDTH-1:0]        STATUS_I,
    output logic                         DATA_READY_O,
    input  logic                         DATA_VALID_I,
    input  logic [DATA_WIDTH-1:0]        DATA_I,
    input  logic                         OUT_READY_I,
    output logic                         OUT_VALID_O,
    output logic [DATA_WIDTH-1:0]        OUT_DATA_O,
    output logic                         OUT_LAST_O
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR    = 3'd1;
    localparam logic [2:0] ST_POLL  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]            state_q;
    logic [CTRL_WIDTH-1:0] control_q;
    logic [STAT_WIDTH-1:0] status_capt_q;
    logic [DATA_WIDTH-1:0] out_data_p1;
    logic                  vld_p1;
    logic                  last_p1;
    logic [CNT_W-1:0]      acc_cnt_q;
    logic [CNT_W-1:0]      word_cnt_q;
    logic                  error_q;

    logic busy;
    logic abort_hit;
    logic ctrl_xfer;
    logic stat_xfer;
    logic event_seen;
    logic data_rdy;
    logic data_xfer;
    logic out_xfer;
    logic timeout_hit;

    always_comb begin
        busy       = (state_q != ST_IDLE);
        abort_hit  = busy && ABORT_I;
        ctrl_xfer  = (state_q == ST_WR) && CONTROL_READY_I;
        stat_xfer  = (state_q == ST_POLL) && STATUS_VALID_I;
        event_seen = stat_xfer && STATUS_I[EVENT_BIT];
        // Refill the output register only when it is empty or draining this edge.
        data_rdy   = (state_q == ST_DRAIN) && (!vld_p1 || OUT_READY_I) && (acc_cnt_q < DEPTH_C);
        data_xfer  = data_rdy && DATA_VALID_I;
        out_xfer   = vld_p1 && OUT_READY_I;
    end

`ifdef STB_READOUT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE_C  = TMO_W'(1);

    logic [TMO_W-1:0] poll_cnt_q;

    assign timeout_hit = (state_q == ST_POLL) && !event_seen && (poll_cnt_q == TMO_LAST_C);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            error_q    <= 1'b0;
            poll_cnt_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && START_I) begin
                error_q <= 1'b0;
            end else if (timeout_hit && !abort_hit) begin
                error_q <= 1'b1;
            end
            if (ctrl_xfer) begin
                poll_cnt_q <= '0;
            end else if (state_q == ST_POLL) begin
                poll_cnt_q <= poll_cnt_q + TMO_ONE_C;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
    assign error_q        = 1'b0;
`endif

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q       <= ST_IDLE;
            control_q     <= '0;
            status_capt_q <= '0;
            out_data_p1   <= '0;
            vld_p1        <= 1'b0;
            last_p1       <= 1'b0;
            acc_cnt_q     <= '0;
            word_cnt_q    <= '0;
        end else if (abort_hit) begin
            state_q <= ST_IDLE;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START_I) begin
                        control_q  <= CONFIG_I;
                        word_cnt_q <= '0;
                        acc_cnt_q  <= '0;
                        state_q    <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (ctrl_xfer) begin
                        state_q <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    if (stat_xfer) begin
                        status_capt_q <= STATUS_I;
                    end
                    if (event_seen) begin
                        state_q <= ST_DRAIN;
                    end else if (timeout_hit) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // Stage p1: one-entry output register between data channel and OUT.
                    if (data_xfer) begin
                        out_data_p1 <= DATA_I;
                        vld_p1      <= 1'b1;
                        last_p1     <= (acc_cnt_q == LAST_C);
                        acc_cnt_q   <= acc_cnt_q + ONE_C;
                    end else if (out_xfer) begin
                        vld_p1  <= 1'b0;
                        last_p1 <= 1'b0;
                    end
                    if (out_xfer) begin
                        word_cnt_q <= word_cnt_q + ONE_C;
                        if (last_p1) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY_O          = busy;
    assign DONE_O          = (state_q == ST_DONE);
    assign ERROR_O         = error_q;
    assign WORD_COUNT_O    = word_cnt_q;
    assign STATUS_CAPT_O   = status_capt_q;
    assign CONTROL_VALID_O = (state_q == ST_WR);
    assign CONTROL_O       = control_q;
    assign STATUS_READY_O  = (state_q == ST_POLL);
    assign DATA_READY_O    = data_rdy;
    assign OUT_VALID_O     = vld_p1;
    assign OUT_DATA_O      = out_data_p1;
    assign OUT_LAST_O      = last_p1;

endmodule

// File: tb/tb_stb_readout_sequencer.sv
// Randomized bench for stb_readout_sequencer: acts as the STB and the transport sink,
// scoring every transfer against a transaction-level model of one capture run.
module tb_stb_readout_sequencer;

    localparam int CTRL_WIDTH     = 32;
    localparam int STAT_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int DEPTH          = 64;
    localparam int EVENT_BIT      = 0;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_W          = $clog2(DEPTH + 1);
`ifdef STB_READOUT_TIMEOUT_EN
    localparam bit FAST_STATUS = 1'b1;
`else
    localparam bit FAST_STATUS = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  RST_I, START_I, ABORT_I;
    logic [CTRL_WIDTH-1:0] CONFIG_I;
    logic                  BUSY_O, DONE_O, ERROR_O;
    logic [CNT_W-1:0]      WORD_COUNT_O;
    logic [STAT_WIDTH-1:0] STATUS_CAPT_O;
    logic                  CONTROL_READY_I, CONTROL_VALID_O;
    logic [CTRL_WIDTH-1:0] CONTROL_O;
    logic                  STATUS_READY_O, STATUS_VALID_I;
    logic [STAT_WIDTH-1:0] STATUS_I;
    logic                  DATA_READY_O, DATA_VALID_I;
    logic [DATA_WIDTH-1:0] DATA_I;
    logic                  OUT_READY_I, OUT_VALID_O, OUT_LAST_O;
    logic [DATA_WIDTH-1:0] OUT_DATA_O;

    int checks = 0;
    int errors = 0;

    stb_readout_sequencer #(
        .CTRL_WIDTH(CTRL_WIDTH), .STAT_WIDTH(STAT_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .DEPTH(DEPTH), .EVENT_BIT(EVENT_BIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK_I(clk), .RST_I(RST_I), .START_I(START_I), .ABORT_I(ABORT_I), .CONFIG_I(CONFIG_I),
        .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ERROR_O(ERROR_O), .WORD_COUNT_O(WORD_COUNT_O),
        .STATUS_CAPT_O(STATUS_CAPT_O),
        .CONTROL_READY_I(CONTROL_READY_I), .CONTROL_VALID_O(CONTROL_VALID_O), .CONTROL_O(CONTROL_O),
        .STATUS_READY_O(STATUS_READY_O), .STATUS_VALID_I(STATUS_VALID_I), .STATUS_I(STATUS_I),
        .DATA_READY_O(DATA_READY_O), .DATA_VALID_I(DATA_VALID_I), .DATA_I(DATA_I),
        .OUT_READY_I(OUT_READY_I), .OUT_VALID_O(OUT_VALID_O), .OUT_DATA_O(OUT_DATA_O),
        .OUT_LAST_O(OUT_LAST_O)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        START_I = 0; ABORT_I = 0; CONFIG_I = '0;
        CONTROL_READY_I = 0; STATUS_VALID_I = 0; STATUS_I = '0;
        DATA_VALID_I = 0; DATA_I = '0; OUT_READY_I = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, BUSY_O, 0);
        check({tag, "_done"}, DONE_O, 0);
        check({tag, "_ctrl_valid"}, CONTROL_VALID_O, 0);
        check({tag, "_stat_ready"}, STATUS_READY_O, 0);
        check({tag, "_data_ready"}, DATA_READY_O, 0);
        check({tag, "_out_valid"}, OUT_VALID_O, 0);
        check({tag, "_out_last"}, OUT_LAST_O, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_quiet(tag);
        check({tag, "_error"}, ERROR_O, 0);
        check({tag, "_count"}, WORD_COUNT_O, 0);
        check({tag, "_control"}, CONTROL_O, 0);
        check({tag, "_capt"}, STATUS_CAPT_O, 0);
        check({tag, "_out_data"}, OUT_DATA_O, 0);
    endtask

    // ready_mode: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
    task automatic run(input logic [31:0] cfg, input int n_zero, input int ctrl_delay,
                       input int ready_mode, input bit full_src, input bit directed,
                       input int abort_at, input bit abort_start);
        logic [31:0] exp_q[$];
        logic [31:0] last_status = '0;
        logic [31:0] st;
        logic [31:0] hold_data = '0;
        int emitted = 0, accepted = 0, ctrl_cnt = 0, stat_cnt = 0, done_cnt = 0;
        int ctrl_wait = 0, cyc = 0, stat_idx = 0, src_idx = 0;
        int first_acc = -1, first_out = -1, last_out = -1;
        bit sv_hold = 0, dv_hold = 0, hold_chk = 0, ctrl_prev = 0;

        idle_inputs();
        CONFIG_I = cfg; START_I = 1; ABORT_I = abort_start;
        tick();
        START_I = 0; ABORT_I = 0; CONFIG_I = $urandom;
        check("busy_after_start", BUSY_O, 1);
        check("count_cleared", WORD_COUNT_O, 0);
        check("error_cleared", ERROR_O, 0);

        while (cyc < 4000 && done_cnt == 0) begin
            if (abort_at >= 0 && emitted == abort_at && stat_cnt > n_zero) begin
                ABORT_I = 1; OUT_READY_I = 0; DATA_VALID_I = 0;
                tick();
                ABORT_I = 0;
                check_quiet("abort");
                check("abort_error", ERROR_O, 0);
                repeat (3) begin
                    tick();
                    check("abort_no_done", DONE_O, 0);
                end
                return;
            end
            CONTROL_READY_I = (ctrl_wait >= ctrl_delay);
            START_I = !directed && ($urandom % 16 == 0);
            CONFIG_I = $urandom;
            if (!sv_hold) begin
                if (directed || FAST_STATUS || ($urandom % 2 == 1)) begin
                    st = directed ? 32'h0 : $urandom;
                    st[EVENT_BIT] = (stat_idx >= n_zero);
                    STATUS_I = st; STATUS_VALID_I = 1; sv_hold = 1;
                end else STATUS_VALID_I = 0;
            end
            if (!dv_hold) begin
                if (full_src || ($urandom % 4 != 0)) begin
                    DATA_I = directed ? src_idx : $urandom; DATA_VALID_I = 1; dv_hold = 1;
                end else DATA_VALID_I = 0;
            end
            case (ready_mode)
                0: OUT_READY_I = 1;
                1: OUT_READY_I = (cyc % 3 == 0);
                default: OUT_READY_I = $urandom % 2;
            endcase
            #4;
            check("word_count_track", WORD_COUNT_O, emitted);
            if (hold_chk) begin
                check("stall_valid", OUT_VALID_O, 1);
                check("stall_data", OUT_DATA_O, hold_data);
                hold_chk = 0;
            end
            if (ctrl_prev) begin
                check("poll_after_ctrl", STATUS_READY_O, 1);
                ctrl_prev = 0;
            end
            if (OUT_VALID_O && !OUT_READY_I) begin
                check("stall_no_accept", DATA_READY_O, 0);
                hold_chk = 1; hold_data = OUT_DATA_O;
            end
            if (accepted == DEPTH) check("no_extra_accept", DATA_READY_O, 0);
            if (CONTROL_VALID_O && CONTROL_READY_I) begin
                ctrl_cnt++; ctrl_prev = 1;
                check("ctrl_word", CONTROL_O, cfg);
            end
            if (CONTROL_VALID_O) ctrl_wait++;
            if (STATUS_READY_O && STATUS_VALID_I) begin
                stat_cnt++; stat_idx++; last_status = STATUS_I; sv_hold = 0;
            end
            if (DATA_READY_O && DATA_VALID_I) begin
                exp_q.push_back(DATA_I); accepted++; src_idx++; dv_hold = 0;
                if (first_acc < 0) first_acc = cyc;
            end
            if (OUT_VALID_O && OUT_READY_I) begin
                check("out_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("out_data", OUT_DATA_O, exp_q.pop_front());
                check("out_last", OUT_LAST_O, emitted == DEPTH - 1);
                if (first_out < 0) first_out = cyc;
                last_out = cyc; emitted++;
            end
            if (DONE_O) done_cnt++;
            tick();
            cyc++;
        end
        idle_inputs();
        check("done_seen", done_cnt, 1);
        check("ctrl_count", ctrl_cnt, 1);
        check("status_count", stat_cnt, n_zero + 1);
        check("status_capt", STATUS_CAPT_O, last_status);
        check("words_emitted", emitted, DEPTH);
        check("word_count_final", WORD_COUNT_O, DEPTH);
        check("queue_empty", exp_q.size(), 0);
        check("done_single", DONE_O, 0);
        check("idle_after_done", BUSY_O, 0);
        check("stat_ready_low", STATUS_READY_O, 0);
        check("error_after_run", ERROR_O, 0);
        if (full_src && ready_mode == 0) begin
            check("latency1", first_out - first_acc, 1);
            check("no_bubbles", last_out - first_out, DEPTH - 1);
        end
    endtask

    initial begin
        int poll_cycles;
        idle_inputs();
        RST_I = 1;
        tick(); tick();
        RST_I = 0;
        check_reset_values("reset");

        run(32'h0000_00F0, 3, 3, 0, 1, 1, -1, 0);
        run($urandom, 2, 1, 1, 1, 0, -1, 0);
        run($urandom, 1, 0, 2, 0, 0, 10, 0);
        run($urandom, 0, 2, 0, 1, 1, -1, 1);
        for (int r = 0; r < 3; r++)
            run($urandom, int'($urandom % 4), int'($urandom % 4), int'($urandom % 3), 0, 0, -1, 0);

        idle_inputs();
        CONFIG_I = 32'hDEAD_BEEF; START_I = 1;
        CONTROL_READY_I = 1; STATUS_VALID_I = 1; STATUS_I = 32'h1;
        DATA_VALID_I = 1; DATA_I = 32'h1234_5678;
        tick();
        START_I = 0;
        repeat (6) tick();
        check("midrun_out_valid", OUT_VALID_O, 1);
        RST_I = 1;
        tick();
        RST_I = 0;
        idle_inputs();
        check_reset_values("midrun_reset");

`ifdef STB_READOUT_TIMEOUT_EN
        idle_inputs();
        CONFIG_I = 32'h55; START_I = 1; CONTROL_READY_I = 1;
        STATUS_VALID_I = 1; STATUS_I = 32'h0;
        tick();
        START_I = 0;
        poll_cycles = 0;
        for (int c = 0; c < 200 && !ERROR_O; c++) begin
            #4;
            if (STATUS_READY_O) poll_cycles++;
            check("timeout_no_done", DONE_O, 0);
            tick();
        end
        check("timeout_error", ERROR_O, 1);
        check("timeout_poll_cycles", poll_cycles, TIMEOUT_CYCLES);
        check("timeout_idle", BUSY_O, 0);
        START_I = 1;
        tick();
        START_I = 0;
        check("timeout_error_cleared", ERROR_O, 0);
        ABORT_I = 1;
        tick();
        ABORT_I = 0;
        check_quiet("timeout_abort");
`else
        poll_cycles = 0;
        idle_inputs();
        CONFIG_I = 32'h55; START_I = 1; CONTROL_READY_I = 1;
        STATUS_VALID_I = 1; STATUS_I = 32'h0;
        tick();
        START_I = 0;
        for (int c = 0; c < 40; c++) begin
            if (STATUS_READY_O) poll_cycles++;
            tick();
        end
        check("poll_indefinite", poll_cycles, 39);
        check("no_error_default", ERROR_O, 0);
        ABORT_I = 1;
        tick();
        ABORT_I = 0;
        check_quiet("poll_abort");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stb_readout_sequencer.md
Name: stb_readout_sequencer

Overview:
- Host-side controller that sequences one complete Streaming Trace Buffer capture.
- Per run: writes the control word over the STB control channel, then polls the status channel until the trigger-event flag is set, then drains exactly DEPTH trace words from the STB data channel.
- Drained words go out on a framed ready/valid stream, which feeds the debug transport (UART/DMI bridge).
- One instance is used per StreamTraceBuffer.

Parameters:
- CTRL_WIDTH, 32, width of the STB control word.
- STAT_WIDTH, 32, width of the STB status word.
- DATA_WIDTH, 32, width of the trace data words (equal to TRB_WIDTH).
- DEPTH, 64, number of words per readout (equal to TRB_DEPTH); minimum 2.
- EVENT_BIT, 0, index of the trigger-event flag within the status word.
- TIMEOUT_CYCLES, 1024, poll watchdog limit; used only with the optional feature.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  synchronous, active-high reset.
- START_I  in  1  single-cycle run request; honoured only in IDLE.
- ABORT_I  in  1  cancels the current run.
- CONFIG_I  in  CTRL_WIDTH  control word; sampled on an accepted START_I.
- BUSY_O  out  1  high in every state except IDLE.
- DONE_O  out  1  one-cycle pulse when a run completes.
- ERROR_O  out  1  sticky watchdog error; cleared by the next accepted START_I.
- WORD_COUNT_O  out  $clog2(DEPTH+1)  number of words emitted on OUT in the current run.
- STATUS_CAPT_O  out  STAT_WIDTH  last status word captured.
- CONTROL_READY_I / CONTROL_VALID_O / CONTROL_O  in / out / out  1 / 1 / CTRL_WIDTH  STB control channel.
- STATUS_READY_O / STATUS_VALID_I / STATUS_I  out / in / in  1 / 1 / STAT_WIDTH  STB status channel.
- DATA_READY_O / DATA_VALID_I / DATA_I  out / in / in  1 / 1 / DATA_WIDTH  STB data channel.
- OUT_READY_I / OUT_VALID_O / OUT_DATA_O / OUT_LAST_O  in / out / out / out  1 / 1 / DATA_WIDTH / 1  framed output stream.

Behaviour:
- Reset: synchronous, active-high on RST_I, one clock CLK_I. On reset:
  - State is IDLE.
  - All outputs are 0.
  - CONTROL_O, STATUS_CAPT_O and OUT_DATA_O are '0.
- Handshakes: a transfer occurs on a rising edge where ready && valid. Valid, once raised, stays high with its payload stable until the transfer.
- IDLE:
  - START_I=1 latches CONFIG_I into CONTROL_O, clears ERROR_O and WORD_COUNT_O, and moves to WR_CTRL.
- WR_CTRL:
  - CONTROL_VALID_O=1.
  - On transfer, moves to POLL, and CONTROL_VALID_O drops the same edge.
- POLL:
  - STATUS_READY_O=1.
  - Every status transfer loads STATUS_I into STATUS_CAPT_O.
  - If STATUS_I[EVENT_BIT]=1, STATUS_READY_O drops and the state moves to DRAIN.
  - Otherwise the state stays in POLL and keeps polling.
- DRAIN:
  - One-entry output register.
  - DATA_READY_O = (!OUT_VALID_O || OUT_READY_I) && (words accepted < DEPTH).
  - Words are accepted on the data channel without bubbles when OUT_READY_I is held high.
  - Each accepted DATA_I appears on OUT_DATA_O with OUT_VALID_O=1 one cycle later (latency 1).
  - OUT_LAST_O=1 exactly with the DEPTH-th word.
  - WORD_COUNT_O increments on each OUT transfer.
  - After the OUT transfer of the last word, moves to DONE.
- DONE:
  - DONE_O=1 for one cycle, then returns to IDLE.
  - WORD_COUNT_O and STATUS_CAPT_O hold until the next START_I.
- START_I while BUSY_O=1: ignored.
- ABORT_I while BUSY_O=1: on the next edge the state returns to IDLE and all valid/ready outputs drop, even mid-beat. A pending OUT word is discarded, DONE_O is not pulsed, and ERROR_O is unchanged.
- ABORT_I and START_I together in IDLE: the start is accepted (abort has no effect in IDLE).
- RST_I mid-run: same as the reset values; any in-flight beat is dropped.
- Extra DATA_VALID_I after DEPTH words: not accepted (DATA_READY_O=0).

Optional Feature:
- Macro: STB_READOUT_TIMEOUT_EN.
- Defined:
  - A poll counter clears on entry to POLL and increments each cycle spent in POLL.
  - When it reaches TIMEOUT_CYCLES without seeing the event flag, ERROR_O is set (sticky) and the state goes to IDLE with no DONE_O pulse.
- Undefined:
  - No counter is built; POLL waits indefinitely (ABORT_I is the only exit).
  - ERROR_O is tied to 0.

Test Plan:
- Basic run: START with CONFIG=32'h0000_00F0, CONTROL_READY after 3 cycles -> exactly one control transfer carrying 32'h0000_00F0; POLL entered the following cycle.
- Status polling: status returns 32'h0 three times, then 32'h0000_0001 -> 4 status transfers; STATUS_CAPT_O=32'h1; DRAIN entered; STATUS_READY_O=0 afterwards.
- Full-rate drain: DATA_I=0..63, OUT_READY_I=1 -> OUT_DATA_O=0..63 on consecutive cycles; OUT_LAST_O only on 63; DONE_O one pulse; WORD_COUNT_O=64.
- Backpressure: OUT_READY_I toggling 1,0,0,1… -> no word lost or duplicated, payload stable while stalled, DATA_READY_O=0 whenever the output register is full and stalled.
- Abort mid-drain: ABORT_I at word 10 -> IDLE next cycle, all valid/ready outputs 0, no DONE_O; a following START runs cleanly from word 0.
- Timeout (macro defined, TIMEOUT_CYCLES=16, status never flags) -> ERROR_O=1 after 16 POLL cycles, back in IDLE; the next START clears ERROR_O.
